// File: rtl/tinygpu_pkg.sv
// Shared tinygpu definitions: default datapath widths and the fetch FSM state encoding.
package tinygpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INST_W_DEF  = 32;
    localparam int TRUNC_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin selector: first eligible request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] index_o
);

    logic [N_REQ-1:0] elig_s;
    logic             found_s;
    logic [IDX_W:0]   cand_s;

    // Scan candidates in rotating priority order and pick the first eligible one
    always_comb begin
        elig_s  = req_i & mask_i;
        grant_o = '0;
        index_o = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(N_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && elig_s[cand_s[IDX_W-1:0]]) begin
                found_s                     = 1'b1;
                grant_o[cand_s[IDX_W-1:0]] = 1'b1;
                index_o                     = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_arbiter.sv
// Shares one instruction memory port among N_REQ cores; one fetch every two cycles,
// round-robin between cores, with all outputs driven straight from registers.
module inst_fetch_arbiter
    import tinygpu_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INST_W  = INST_W_DEF,
    parameter int TRUNC_W = TRUNC_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [INST_W-1:0]            mem_data,
    output logic [INST_W-1:0]            rdata,
    output logic [N_REQ-1:0]             rvalid,
    output logic                         rerr,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_REQ);

    fetch_state_e      state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] rdata_q, rdata_d;
    logic [N_REQ-1:0]  rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  win_onehot_s;
    logic [N_REQ-1:0]  arb_mask_s;
    logic [N_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]  grant_idx_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req),
        .mask_i  (arb_mask_s),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .index_o (grant_idx_s)
    );

    // The core just being answered must not win the slot that follows its own response
    always_comb begin
        win_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
        if (state_q == ST_RESP) begin
            arb_mask_s = ~win_onehot_s;
        end else begin
            arb_mask_s = '1;
        end
    end

    // Next-state, grant bookkeeping and registered-output precomputation
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rvalid_d = '0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (|grant_s) begin
                    win_d   = grant_idx_s;
                    addr_d  = req_addr[grant_idx_s];
                    ptr_d   = (grant_idx_s == IDX_W'(N_REQ-1)) ? '0 : grant_idx_s + IDX_W'(1);
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                rdata_d  = mem_data;
                rerr_d   = |addr_q[ADDR_W-1:TRUNC_W];
                rvalid_d = win_onehot_s;
                state_d  = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_ISSUE) begin
            mem_addr_d = addr_d;
        end else begin
            mem_addr_d = '0;
        end
    end

    // State and output registers; reset drops any in-flight fetch silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= '0;
            rerr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign rerr     = rerr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// Directed and random stimulus for inst_fetch_arbiter, checked each cycle against a
// transaction-level model of the fetch schedule and round-robin order.
module tb_inst_fetch_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int IW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req;
    logic [N-1:0][AW-1:0] req_addr;
    logic [AW-1:0]        mem_addr;
    logic [IW-1:0]        mem_data;
    logic [IW-1:0]        rdata;
    logic [N-1:0]         rvalid;
    logic                 rerr;
    logic                 busy;

    logic [IW-1:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    // model: a fetch is either waiting for its data cycle (m_issue) or being answered (m_resp)
    bit            m_issue, m_resp;
    int            m_win, m_ptr;
    logic [AW-1:0] m_addr;
    logic [N-1:0]  exp_rvalid;
    logic [IW-1:0] exp_rdata;
    logic          exp_rerr;

    inst_fetch_arbiter #(.N_REQ(N), .ADDR_W(AW), .INST_W(IW), .TRUNC_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_addr (req_addr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rerr     (rerr),
        .busy     (busy)
    );

    assign mem_data = mem[mem_addr[5:0]];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_issue    = 0;
        m_resp     = 0;
        m_win      = 0;
        m_ptr      = 0;
        m_addr     = '0;
        exp_rvalid = '0;
        exp_rdata  = '0;
        exp_rerr   = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        int w;
        if (m_issue) begin
            exp_rvalid        = '0;
            exp_rvalid[m_win] = 1'b1;
            exp_rdata         = mem[m_addr[5:0]];
            exp_rerr          = (m_addr >= 16'd64);
            m_issue           = 0;
            m_resp            = 1;
        end else begin
            elig = req;
            if (m_resp) elig[m_win] = 1'b0;
            exp_rvalid = '0;
            m_resp     = 0;
            w          = -1;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (w < 0 && elig[c]) w = c;
            end
            if (w >= 0) begin
                m_win   = w;
                m_ptr   = (w + 1) % N;
                m_addr  = req_addr[w];
                m_issue = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("rvalid", rvalid, exp_rvalid);
        chk("rdata", rdata, exp_rdata);
        chk("rerr", rerr, exp_rerr);
        chk("busy", busy, (m_issue || m_resp));
        chk("mem_addr", mem_addr, m_issue ? m_addr : 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check_outputs();
    endtask

    int order[$];
    int ocyc[$];
    int last_seen [N];
    int cyc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[5]   = 32'hDEADBEEF;
        req      = '0;
        req_addr = '0;
        rst_n    = 1'b0;
        model_reset();
        #12;
        check_outputs();
        tick();
        rst_n = 1'b1;
        tick();

        // single fetch from core 2
        req         = 4'b0100;
        req_addr[2] = 16'h0005;
        tick();
        tick();
        chk("single_rvalid", rvalid, 4'b0100);
        chk("single_rdata", rdata, 32'hDEADBEEF);
        chk("single_rerr", rerr, 1'b0);
        req = '0;
        tick();
        tick();
        chk("single_rdata_hold", rdata, 32'hDEADBEEF);

        // out-of-range address wraps onto mem[1] and flags rerr
        req         = 4'b0010;
        req_addr[1] = 16'h0041;
        tick();
        tick();
        chk("range_rvalid", rvalid, 4'b0010);
        chk("range_rerr", rerr, 1'b1);
        chk("range_rdata", rdata, mem[1]);
        req = '0;
        tick();
        tick();

        // early drop while in ISSUE
        req         = 4'b0001;
        req_addr[0] = 16'h0009;
        tick();
        req = '0;
        tick();
        chk("drop_rvalid", rvalid, 4'b0001);
        tick();
        chk("drop_idle_busy", busy, 1'b0);
        chk("drop_no_second", rvalid, 4'b0000);

        // contention from reset
        rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) req_addr[i] = AW'(3 * i + 10);
        req = 4'b1111;
        order.delete();
        ocyc.delete();
        for (int c = 0; c < 16; c++) begin
            tick();
            if (order.size() < N) chk("cont_busy", busy, 1'b1);
            for (int i = 0; i < N; i++) begin
                if (rvalid[i]) begin
                    order.push_back(i);
                    ocyc.push_back(c);
                end
            end
            req = req & ~rvalid;
            if (order.size() == N) break;
        end
        chk("cont_count", order.size(), N);
        for (int i = 0; i < order.size(); i++) chk("cont_order", order[i], i);
        for (int i = 1; i < ocyc.size(); i++) chk("cont_gap", ocyc[i] - ocyc[i-1], 2);
        req = '0;
        tick();
        tick();

        // fairness between cores 0 and 3
        req_addr[0] = 16'h0003;
        req_addr[3] = 16'h0030;
        req         = 4'b1001;
        order.delete();
        last_seen[0] = 0;
        last_seen[3] = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (rvalid[0] || rvalid[3]) begin
                int w;
                w = rvalid[0] ? 0 : 3;
                if (order.size() > 0) chk("fair_alternate", (order[order.size()-1] != w), 1'b1);
                if (order.size() > 1) chk("fair_wait", ((c - last_seen[w]) <= 4), 1'b1);
                order.push_back(w);
                last_seen[w] = c;
            end
        end
        chk("fair_enough", (order.size() >= 8), 1'b1);
        req = '0;
        tick();
        tick();
        tick();

        // reset during ISSUE
        req         = 4'b0001;
        req_addr[0] = 16'h0002;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        req = '0;
        tick();
        rst_n       = 1'b1;
        req_addr[1] = 16'h0007;
        req_addr[3] = 16'h0008;
        req         = 4'b1010;
        tick();
        tick();
        chk("rst_first", rvalid, 4'b0010);
        req[1] = 1'b0;
        tick();
        tick();
        chk("rst_second", rvalid, 4'b1000);
        req = '0;
        tick();
        tick();

        // random traffic; address only changes while a core is idle
        cyc = 0;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_addr[i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
                        req[i]      = 1'b1;
                    end
                end else if (rvalid[i]) begin
                    req[i] = ($urandom_range(0, 1) == 1);
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_arbiter.md
INST_FETCH_ARBITER -- requirements
Module: inst_fetch_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of shader cores sharing the instruction memory port (2..8).
REQ-002 Parameter ADDR_W, default 16: instruction address width.
REQ-003 Parameter INST_W, default 32: instruction word width.
REQ-004 Parameter TRUNC_W, default 6: implemented memory address bits (64 locations).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req  input  N_REQ  per-core fetch request, level, held until its rvalid.
REQ-009 req_addr  input  N_REQ x ADDR_W  per-core fetch address, stable while req is high.
REQ-010 mem_addr  output  ADDR_W  address to the shared instruction memory (combinational read).
REQ-011 mem_data  input  INST_W  instruction word from memory, same cycle as mem_addr.
REQ-012 rdata  output  INST_W  registered instruction, shared by all cores.
REQ-013 rvalid  output  N_REQ  one-hot, one-cycle pulse marking rdata owner.
REQ-014 rerr  output  1  high with rvalid when the served address had nonzero bits above TRUNC_W.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP.
REQ-017 IDLE: if any req high, latch round-robin winner index and its address, go ISSUE; else stay.
REQ-018 ISSUE: drive mem_addr from latched address; at the edge, register mem_data into rdata, compute rerr, go RESP.
REQ-019 RESP: rvalid[winner]=1 for exactly this cycle; rdata/rerr hold until the next RESP.
REQ-020 RESP: arbitrate among req masked by ~winner; if any, latch new winner and go ISSUE, else go IDLE.
REQ-021 Latency: req sampled in IDLE at edge k -> rvalid high in cycle k+2; back-to-back service every 2 cycles.
REQ-022 Round-robin: priority starts at (last winner + 1) mod N_REQ; pointer updates only on a grant.
REQ-023 A core holding req high after its rvalid is a new request, eligible from the next arbitration.
REQ-024 A core dropping req before rvalid: the in-flight fetch completes and rvalid still pulses (no cancel).
REQ-025 mem_addr SHALL be the latched address in ISSUE and all-zero otherwise.
REQ-026 rerr = OR of latched address bits [ADDR_W-1:TRUNC_W]; data still returned from the truncated address.
REQ-027 All-requests-simultaneous: served strictly in round-robin order; no core starves (max wait 2*N_REQ cycles).

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, rvalid=0, rdata=0, rerr=0, busy=0, mem_addr=0, pointer=0.
REQ-029 Reset mid-fetch SHALL abort the fetch with no rvalid; first grant after reset goes to the lowest-index requester.

Structure
REQ-030 INST_W, ADDR_W, TRUNC_W defaults and the FSM state enum SHALL live in shared package tinygpu_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (req, mask, pointer in; one-hot grant and index out, combinational).
REQ-032 All registers in inst_fetch_arbiter; rr_arbiter has no state.

Verification
REQ-033 Single: req[2]=1, req_addr[2]=0x0005, mem[5]=0xDEADBEEF -> rvalid=0b0100 and rdata=0xDEADBEEF two cycles later, rerr=0.
REQ-034 Contention: req=0b1111 from reset, held, each core dropped after its rvalid -> rvalid order 0,1,2,3, pulses 2 cycles apart, busy high throughout.
REQ-035 Fairness: core 0 and core 3 hold req continuously for 20 cycles -> grants alternate 0,3,0,3; neither waits more than 4 cycles.
REQ-036 Range: req_addr[1]=0x0041 -> rvalid[1] with rerr=1 and rdata=mem[1].
REQ-037 Reset: rst_n low during ISSUE -> outputs zero immediately, no rvalid; after release req=0b1010 -> core 1 served first.
REQ-038 Early drop: req[0] deasserted in ISSUE -> rvalid[0] still pulses once, FSM returns to IDLE.
